// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, constants and the fetch queue entry type.
package fetch_pkg;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [DW-1:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
    logic          misalign;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry circular buffer of fetch entries; flush empties it by snapping head to tail.
module fetch_queue import fetch_pkg::*; #(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  fetch_entry_t  i_entry,
  output fetch_entry_t  o_entry,
  output logic [CW-1:0] o_count
);
  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  assign o_entry = r_mem[r_head];
  assign o_count = r_count;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= r_tail;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_entry;
        r_tail        <= r_tail + 1'b1;
      end
      if (i_pop) r_head <= r_head + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and fetch queue front-end for inst_rom, with redirect flush.
// Optional misaligned-redirect trap enabled by FETCH_MISALIGN_TRAP_EN.
module fetch_unit import fetch_pkg::*; #(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter int            DEPTH    = 2,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_instr,
  input  logic          stall_i,
  input  logic          redirect_i,
  input  logic [AW-1:0] redirect_pc_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_pc,
  output logic [DW-1:0] out_instr,
  output logic          out_misalign
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [AW-1:0] r_pc;
  logic          r_mis;
  logic          r_halt;
  logic [AW-1:0] w_target;
  logic [CW-1:0] w_count;
  logic          w_push;
  logic          w_pop;
  fetch_entry_t  w_in;
  fetch_entry_t  w_head;
  assign rom_addr     = r_pc;
  assign out_valid    = (w_count != '0) && !redirect_i;
  assign w_pop        = out_valid && out_ready;
  assign w_push       = !stall_i && !redirect_i && !r_halt && ((w_count < CW'(DEPTH)) || w_pop);
  assign w_in         = '{pc: r_pc, instr: rom_instr, misalign: r_mis};
  assign out_pc       = w_head.pc;
  assign out_instr    = out_valid ? w_head.instr : NOP_INSTR;
  assign out_misalign = out_valid && w_head.misalign;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign w_target = redirect_pc_i;
  // The flag rides on exactly one pushed entry, after which fetch stays halted until redirect/reset.
  always_ff @(posedge clk) begin
    if (rst || redirect_i) begin
      r_mis  <= !rst && (redirect_pc_i[1:0] != 2'b00);
      r_halt <= 1'b0;
    end else if (w_push && r_mis) begin
      r_mis  <= 1'b0;
      r_halt <= 1'b1;
    end
  end
`else
  assign w_target = redirect_pc_i & ~AW'(3);
  assign r_mis    = 1'b0;
  assign r_halt   = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) r_pc <= RESET_PC;
    else if (redirect_i) r_pc <= w_target;
    else if (w_push) r_pc <= r_pc + AW'(INSTR_BYTES);
  end
  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_i),
    .i_entry (w_in),
    .o_entry (w_head),
    .o_count (w_count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table plus randomized traffic checked against a queue-based model.
module tb_fetch_unit;
  localparam int DEPTH = 2;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] rom_addr, rom_instr, out_pc, out_instr;
  logic        out_valid, out_misalign;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  assign rom_instr = rom_addr >> 2;
  fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_instr(rom_instr),
    .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_misalign(out_misalign)
  );
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic mis; } ent_t;
  ent_t        q[$];
  logic [31:0] m_pc = '0;
  logic        m_flag = 1'b0;
  logic        m_halt = 1'b0;
  bit          m_known = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask
  // One clock: drive, sample mid-cycle against the model, then advance the model across the edge.
  task automatic step(input logic r, input logic s, input logic d, input logic [31:0] t, input logic y,
                      output logic sv, output logic [31:0] spc, output logic smis, output logic [31:0] sa);
    bit v, pop, full;
    @(negedge clk);
    rst = r; stall_i = s; redirect_i = d; redirect_pc_i = t; out_ready = y;
    #1;
    sv = out_valid; spc = out_pc; smis = out_misalign; sa = rom_addr;
    v = (q.size() != 0) && !d;
    if (m_known) begin
      chk("rom_addr", rom_addr, m_pc);
      chk("out_valid", {31'b0, out_valid}, {31'b0, v});
      if (v) begin
        chk("out_pc", out_pc, q[0].pc);
        chk("out_instr", out_instr, q[0].instr);
        chk("out_misalign", {31'b0, out_misalign}, {31'b0, q[0].mis});
      end
    end
    if (r) begin
      q.delete(); m_pc = '0; m_flag = 0; m_halt = 0; m_known = 1;
    end else if (d) begin
      q.delete();
      m_pc = TRAP ? t : (t & ~32'h3);
      m_flag = TRAP && (t[1:0] != 2'b00);
      m_halt = 0;
    end else begin
      pop = v && y;
      full = q.size() >= DEPTH;
      if (pop) void'(q.pop_front());
      if (!s && !m_halt && (!full || pop)) begin
        q.push_back('{m_pc, m_pc >> 2, m_flag});
        if (m_flag) begin m_flag = 0; m_halt = 1; end
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
  endtask
  typedef struct { logic r, s, d; logic [31:0] t; logic y, c, v; logic [31:0] pc; logic mis; } vec_t;
  vec_t tab[$];
  function automatic void add(logic r, logic s, logic d, logic [31:0] t, logic y,
                              logic c, logic v, logic [31:0] pc, logic mis);
    tab.push_back('{r, s, d, t, y, c, v, pc, mis});
  endfunction
  initial begin
    logic        sv, smis;
    logic [31:0] spc, sa;
    step(1, 0, 0, 0, 0, sv, spc, smis, sa);
    // streaming from reset
    add(1,0,0,0,1, 0,0,0,0);
    add(0,0,0,0,1, 1,0,0,0);
    add(0,0,0,0,1, 1,1,0,0);
    add(0,0,0,0,1, 1,1,4,0);
    add(0,0,0,0,1, 1,1,8,0);
    add(0,0,0,0,1, 1,1,12,0);
    // back-pressure fills the queue, then drains in order
    add(1,0,0,0,1, 0,0,0,0);
    add(0,0,0,0,0, 1,0,0,0);
    for (int i = 0; i < 4; i++) add(0,0,0,0,0, 1,1,0,0);
    add(0,0,0,0,1, 1,1,0,0);
    add(0,0,0,0,1, 1,1,4,0);
    add(0,0,0,0,0, 1,1,8,0);
    // redirect over a full queue
    add(0,0,1,32'h100,1, 1,0,0,0);
    add(0,0,0,0,1, 1,0,0,0);
    add(0,0,0,0,1, 1,1,32'h100,0);
    add(0,0,0,0,1, 1,1,32'h104,0);
    // stall drains queue, pc held
    add(0,1,0,0,1, 1,1,32'h108,0);
    add(0,1,0,0,1, 1,0,0,0);
    add(0,1,0,0,1, 1,0,0,0);
    add(0,0,0,0,1, 1,0,0,0);
    add(0,0,0,0,1, 1,1,32'h10C,0);
    // PC wrap
    add(0,0,1,32'hFFFF_FFF8,1, 1,0,0,0);
    add(0,0,0,0,1, 1,0,0,0);
    add(0,0,0,0,1, 1,1,32'hFFFF_FFF8,0);
    add(0,0,0,0,1, 1,1,32'hFFFF_FFFC,0);
    add(0,0,0,0,1, 1,1,32'h0,0);
    // misaligned redirect
    add(0,0,1,32'h102,1, 1,0,0,0);
    add(0,0,0,0,1, 1,0,0,0);
    add(0,0,0,0,1, 1,1,TRAP ? 32'h102 : 32'h100,TRAP);
    add(0,0,0,0,1, 1,!TRAP,32'h104,0);
    add(0,0,0,0,1, 1,!TRAP,32'h108,0);
    // mid-run reset
    add(1,0,0,0,1, 0,0,0,0);
    add(0,0,0,0,1, 1,0,0,0);
    add(0,0,0,0,1, 1,1,0,0);
    foreach (tab[i]) begin
      step(tab[i].r, tab[i].s, tab[i].d, tab[i].t, tab[i].y, sv, spc, smis, sa);
      if (tab[i].c) begin
        chk($sformatf("tab%0d_valid", i), {31'b0, sv}, {31'b0, tab[i].v});
        if (tab[i].v) begin
          chk($sformatf("tab%0d_pc", i), spc, tab[i].pc);
          chk($sformatf("tab%0d_mis", i), {31'b0, smis}, {31'b0, tab[i].mis});
        end
      end
    end
    // redirect during stall still loads the PC
    step(0, 1, 1, 32'h200, 1, sv, spc, smis, sa);
    step(0, 1, 0, 0, 1, sv, spc, smis, sa);
    chk("stall_redirect_addr", sa, 32'h200);
    chk("stall_redirect_valid", {31'b0, sv}, 32'h0);
    // reset beats a simultaneous redirect
    step(0, 0, 0, 0, 1, sv, spc, smis, sa);
    step(1, 0, 1, 32'h300, 1, sv, spc, smis, sa);
    step(0, 0, 0, 0, 1, sv, spc, smis, sa);
    chk("rst_vs_redirect_addr", sa, 32'h0);
    chk("rst_vs_redirect_valid", {31'b0, sv}, 32'h0);
    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic        r, s, d, y;
      logic [31:0] t;
      r = ($urandom_range(0, 59) == 0);
      s = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 11) == 0);
      y = ($urandom_range(0, 3) != 0);
      t = $urandom;
      if ($urandom_range(0, 1) == 0) t[1:0] = 2'b00;
      step(r, s, d, t, y, sv, spc, smis, sa);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
